sound_cmd_port: RTL and testbench
=================================

# sound_cmd_port

Main-CPU-side endpoint of the sound board's command/reply latch pair. It accepts command bytes from the main CPU bus into a small FIFO and drains them into the sound board's command latch at a guaranteed minimum spacing. It returns the sound CPU's reply byte to the main CPU and raises a main-CPU interrupt when a new reply is posted. It sits in the main board I/O decode, directly wired to the sound board's `latch_wr/latch_din/latch_rd/latch_dout/latch_rdy`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `GAP`, 256: minimum `clk_sys` cycles between successive `latch_wr` pulses; ≥2.

- `clk_sys`  in  1  system clock (40 MHz)
- `reset`  in  1  synchronous, active-high reset
- `cs`  in  1  port select from main I/O decode
- `wr`  in  1  one-cycle write strobe, qualified by `cs`
- `rd`  in  1  one-cycle read strobe, qualified by `cs`
- `reg_sel`  in  2  0 = command write / reply read; 1 = status read / control write; 2 = IRQ ack write; 3 = reserved
- `din`  in  8  write data
- `dout`  out  8  read data, registered
- `irq`  out  1  level interrupt request to main CPU
- `latch_wr`  out  1  one-cycle pulse into sound command latch
- `latch_din`  out  8  command byte; valid while `latch_wr` is high
- `latch_rd`  out  1  one-cycle pulse acknowledging the reply latch
- `latch_dout`  in  8  sound reply byte
- `latch_rdy`  in  1  reply-pending flag from sound board

## Operation
- Command write (`cs&wr`, sel 0):
  - If the FIFO is not full at the start of the cycle, push `din`.
  - Otherwise drop the byte and set sticky `ovf`.
  - Full is judged before any same-cycle pop. A push to a full FIFO is rejected even when a pop happens in the same cycle.
- Drain FSM, states IDLE / SEND / HOLD:
  - IDLE → SEND when the FIFO is non-empty.
  - SEND: drive `latch_wr`=1 and `latch_din`=head, pop, load gap counter with `GAP-1`, go to HOLD.
  - HOLD: decrement the counter. At 0, go to SEND if the FIFO is non-empty, else IDLE.
- Reply read (`cs&rd`, sel 0): `dout`←`latch_dout`; `latch_rd` pulses on the following cycle; the `irq` pending bit clears.
- Status read (`cs&rd`, sel 1): `dout` = {3'b0, `ovf`, `irq_pend`, `latch_rdy`, full, empty}. The read clears `ovf`.
- Control write (sel 1): `din[0]` = `irq_en`; `din[1]`=1 flushes the FIFO and returns the FSM to IDLE. A SEND in the same cycle as the flush is suppressed.
- IRQ ack write (sel 2): clears `irq_pend`.
- Reads with sel 2/3 return 8'hFF. Writes with sel 3 are ignored.
- `irq_pend` sets on a registered rising edge of `latch_rdy`. If set and clear happen in the same cycle, set wins.
- `irq` = `irq_pend & irq_en`.

## Timing
- Reset values:
  - outputs: `dout`=8'hFF, `irq`=0, `latch_wr`=0, `latch_din`=0, `latch_rd`=0
  - internal: FIFO empty, FSM IDLE, counter 0, `ovf`=0, `irq_pend`=0, `irq_en`=1, registered `latch_rdy`=0 (so a `latch_rdy` already high at reset release raises `irq_pend` one cycle later).
- Reset mid-HOLD: gap aborts; the next `latch_wr` may occur 2 cycles after a push.
- Push at cycle t into an empty FIFO in IDLE: `latch_wr` at t+2 (FIFO registered at t+1, SEND at t+2).
- Successive `latch_wr` pulses are exactly `GAP` cycles apart while the FIFO stays non-empty.
- `dout` is valid the cycle after `rd`; it holds until the next read.
- `latch_rd` is asserted at t+1 for a reply read at t.
- `latch_rdy` rising at t: `irq` high at t+2.
- FIFO pointers wrap modulo `DEPTH`. The count has `$clog2(DEPTH)+1` bits.

## Structure
- Package `sound_cmd_pkg`:
  - `reg_sel` constants: `SEL_DATA`, `SEL_STAT`, `SEL_ACK`
  - status bit indices
  - FSM enum `drain_state_t`
- Sub-module `sound_cmd_fifo`: synchronous FIFO with `DEPTH` × 8 entries; push, pop, head, full, empty, flush; no read latency on head.
- Top level holds the FSM, gap counter, IRQ logic and bus decode.

## Test plan
- Write 8'h5A at t=10 → `latch_wr` at t=12 with `latch_din`=5A; no further `latch_wr`.
- Write 01,02,03,04 on consecutive cycles (`GAP`=256) → `latch_wr` at t0, t0+256, t0+512, t0+768 carrying 01..04 in order.
- Write 5 bytes back-to-back while the FIFO is not yet draining → 5th dropped; status read = 8'h12 (full+`ovf`); second status read shows `ovf`=0.
- Raise `latch_rdy` with `latch_dout`=8'hC3 → `irq`=1 two cycles later; reply read returns C3; `latch_rd` pulses once; `irq`=0.
- Control write 8'h00, then raise `latch_rdy` → `irq` stays 0, status bit3=1; control write 8'h01 → `irq`=1; ack write → `irq`=0.
- Assert `reset` during HOLD with 2 bytes queued → no `latch_wr` afterward; status = 8'h01 (empty, `latch_rdy`=0).

Source files
------------

// File: rtl/sound_cmd_pkg.sv
// Shared definitions for the sound command/reply port: register selects,
// status bit positions and the drain FSM encoding.
package sound_cmd_pkg;

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_STAT = 2'd1;
  localparam logic [1:0] SEL_ACK  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_RDY   = 2;
  localparam int ST_IRQ   = 3;
  localparam int ST_OVF   = 4;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam logic [7:0] READ_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } drain_state_t;

  function automatic logic [7:0] pack_status(input logic ovf, input logic irq_pend,
                                             input logic rdy, input logic full,
                                             input logic empty);
    logic [7:0] s;
    s           = '0;
    s[ST_OVF]   = ovf;
    s[ST_IRQ]   = irq_pend;
    s[ST_RDY]   = rdy;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/sound_cmd_port_if.sv
// Main-CPU register bus of the sound command port.
// Strobes: wr and rd are single-cycle and only act when cs is high; there is no
// back-pressure, and dout is valid the cycle after rd and holds until the next read.
interface sound_cmd_port_if;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [1:0] reg_sel;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, wr, rd, reg_sel, din, input dout, irq);
  modport slave  (input cs, wr, rd, reg_sel, din, output dout, irq);
endinterface

// File: rtl/sound_cmd_fifo.sv
// Command byte FIFO: DEPTH x 8, head visible combinationally, flush clears it.
module sound_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for a push.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sound_cmd_port.sv
// Main-CPU endpoint of the sound board latches: queues command bytes and paces
// them into the command latch, returns reply bytes and raises the reply IRQ.
module sound_cmd_port
  import sound_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 256
) (
  input  logic               clk_sys,
  input  logic               reset,
  sound_cmd_port_if.slave    bus,
  output logic               latch_wr,
  output logic [7:0]         latch_din,
  output logic               latch_rd,
  input  logic [7:0]         latch_dout,
  input  logic               latch_rdy,
  output drain_state_t       dbg_state
);

  localparam int CW = $clog2(GAP);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  logic         wr_acc, rd_acc;
  logic         cmd_wr, ctl_wr, ack_wr;
  logic         rep_rd, stat_rd;
  logic         flush;

  logic [7:0]   fifo_head;
  logic         fifo_full, fifo_empty;
  logic         fifo_pop;

  drain_state_t state;
  logic [CW-1:0] gap_cnt;

  logic         ovf;
  logic         irq_pend;
  logic         irq_en;
  logic         rdy_q;
  logic         rdy_rise;
  logic [7:0]   status;

  assign wr_acc  = bus.cs & bus.wr;
  assign rd_acc  = bus.cs & bus.rd;
  assign cmd_wr  = wr_acc & (bus.reg_sel == SEL_DATA);
  assign ctl_wr  = wr_acc & (bus.reg_sel == SEL_STAT);
  assign ack_wr  = wr_acc & (bus.reg_sel == SEL_ACK);
  assign rep_rd  = rd_acc & (bus.reg_sel == SEL_DATA);
  assign stat_rd = rd_acc & (bus.reg_sel == SEL_STAT);
  assign flush   = ctl_wr & bus.din[CTRL_FLUSH];

  assign fifo_pop  = (state == S_SEND);
  assign rdy_rise  = latch_rdy & ~rdy_q;
  assign dbg_state = state;

  always_comb begin
    status = pack_status(ovf, irq_pend, latch_rdy, fifo_full, fifo_empty);
  end

  sound_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (cmd_wr),
    .push_data (bus.din),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // latch_wr is registered on entry to SEND so it is high exactly while the
  // FSM sits in SEND; a flush blocks that entry, suppressing the send.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      latch_wr  <= 1'b0;
      latch_din <= '0;
    end else begin
      latch_wr <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        gap_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!fifo_empty) begin
              state     <= S_SEND;
              latch_wr  <= 1'b1;
              latch_din <= fifo_head;
            end
          end
          S_SEND: begin
            gap_cnt <= GAP_LOAD;
            state   <= S_HOLD;
          end
          S_HOLD: begin
            gap_cnt <= gap_cnt - CW'(1);
            if (gap_cnt == CW'(1)) begin
              if (!fifo_empty) begin
                state     <= S_SEND;
                latch_wr  <= 1'b1;
                latch_din <= fifo_head;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Read data, reply acknowledge, sticky overflow and interrupt bookkeeping.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.dout <= READ_IDLE;
      bus.irq  <= 1'b0;
      latch_rd <= 1'b0;
      ovf      <= 1'b0;
      irq_pend <= 1'b0;
      irq_en   <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q    <= latch_rdy;
      latch_rd <= rep_rd;

      if (rep_rd)       bus.dout <= latch_dout;
      else if (stat_rd) bus.dout <= status;
      else if (rd_acc)  bus.dout <= READ_IDLE;

      if (cmd_wr && fifo_full) ovf <= 1'b1;
      else if (stat_rd)        ovf <= 1'b0;

      if (rdy_rise)              irq_pend <= 1'b1;
      else if (rep_rd || ack_wr) irq_pend <= 1'b0;

      if (ctl_wr) irq_en <= bus.din[CTRL_IRQ_EN];

      bus.irq <= irq_pend & irq_en;
    end
  end

endmodule

// File: tb/tb_sound_cmd_port.sv
// Self-checking bench for sound_cmd_port: directed scenarios plus random
// command traffic scored against a send-time model of the pacing rules.
module tb_sound_cmd_port;
  import sound_cmd_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 256;
  localparam int NEVER = -1000000;

  logic         clk_sys = 1'b0;
  logic         reset   = 1'b1;
  logic         latch_wr;
  logic [7:0]   latch_din;
  logic         latch_rd;
  logic [7:0]   latch_dout = 8'h00;
  logic         latch_rdy  = 1'b0;
  drain_state_t dbg_state;

  sound_cmd_port_if bus();

  sound_cmd_port #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .latch_wr   (latch_wr),
    .latch_din  (latch_din),
    .latch_rd   (latch_rd),
    .latch_dout (latch_dout),
    .latch_rdy  (latch_rdy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         last_send = NEVER;
  bit         m_ovf = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_en = 1'b1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         rd_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int occ(input int c);
    int n = 0;
    foreach (exp_t[i]) if (exp_t[i] >= c) n++;
    return n;
  endfunction

  function automatic bit send_at(input int c);
    foreach (exp_t[i]) if (exp_t[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk_sys) begin
    if (latch_rd) rd_pulses++;
    while (exp_t.size() > 0 && exp_t[0] < cyc) begin
      chk("latch_wr_missed", cyc, exp_t[0]);
      void'(exp_t.pop_front());
      void'(exp_q.pop_front());
    end
    if (latch_wr) begin
      if (exp_t.size() == 0) begin
        chk("latch_wr_unexpected", {24'h0, latch_din}, 32'hFFFF_FFFF);
      end else begin
        chk("latch_wr_time", cyc, exp_t[0]);
        chk("latch_din", {24'h0, latch_din}, {24'h0, exp_q[0]});
        void'(exp_t.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic model_clear();
    exp_t.delete();
    exp_q.delete();
    last_send = NEVER;
    m_ovf  = 1'b0;
    m_pend = 1'b0;
    m_en   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    idle(2);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] data);
    int s;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.reg_sel = sel; bus.din = data;
    if (sel == SEL_DATA) begin
      if (occ(cyc) < DEPTH) begin
        s = (cyc + 2 > last_send + GAP) ? cyc + 2 : last_send + GAP;
        exp_t.push_back(s);
        exp_q.push_back(data);
        last_send = s;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (sel == SEL_STAT) begin
      m_en = data[0];
      if (data[1]) begin
        for (int i = exp_t.size() - 1; i >= 0; i--) begin
          if (exp_t[i] > cyc) begin
            exp_t.delete(i);
            exp_q.delete(i);
          end
        end
        last_send = NEVER;
      end
    end else if (sel == SEL_ACK) begin
      m_pend = 1'b0;
    end
    idle(1);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [7:0] data);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.reg_sel = sel;
    idle(1);
    bus.cs = 1'b0; bus.rd = 1'b0;
    data = bus.dout;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] exp_s, got;
    int n;
    n = occ(cyc);
    exp_s = {3'b000, m_ovf, m_pend, latch_rdy, (n == DEPTH), (n == 0)};
    bus_read(SEL_STAT, got);
    chk(tag, {24'h0, got}, {24'h0, exp_s});
    m_ovf = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = GAP * (DEPTH + 2) + 10;
    while (exp_t.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    chk(tag, exp_t.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rdat;
    int n;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.reg_sel = 2'd0; bus.din = 8'h00;
    @(posedge clk_sys); #1;
    do_reset();

    chk("rst_dout", {24'h0, bus.dout}, 32'hFF);
    chk("rst_irq", {31'h0, bus.irq}, 0);
    chk("rst_latch_wr", {31'h0, latch_wr}, 0);
    chk("rst_latch_din", {24'h0, latch_din}, 0);
    chk("rst_latch_rd", {31'h0, latch_rd}, 0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    check_status("rst_status");

    // single command byte
    bus_write(SEL_DATA, 8'h5A);
    drain("single_drain");
    idle(GAP + 20);

    // four bytes back to back: GAP spacing
    bus_write(SEL_DATA, 8'h01);
    bus_write(SEL_DATA, 8'h02);
    bus_write(SEL_DATA, 8'h03);
    bus_write(SEL_DATA, 8'h04);
    drain("burst4_drain");
    idle(GAP);

    // overflow while the FSM is holding off
    bus_write(SEL_DATA, 8'hAA);
    idle(3);
    for (int k = 0; k < 5; k++) bus_write(SEL_DATA, 8'hB0 + 8'(k));
    check_status("ovf_status");
    check_status("ovf_cleared_status");
    drain("ovf_drain");
    idle(GAP);

    // reserved selects
    bus_read(SEL_ACK, rdat);
    chk("rd_sel2", {24'h0, rdat}, 32'hFF);
    bus_write(SEL_RSVD, 8'h02);
    bus_read(SEL_RSVD, rdat);
    chk("rd_sel3", {24'h0, rdat}, 32'hFF);

    // reply with IRQ
    latch_dout = 8'hC3;
    latch_rdy  = 1'b1;
    m_pend     = 1'b1;
    idle(1);
    chk("irq_t1", {31'h0, bus.irq}, 0);
    idle(1);
    chk("irq_t2", {31'h0, bus.irq}, {31'h0, m_pend & m_en});
    rd_pulses = 0;
    bus_read(SEL_DATA, rdat);
    m_pend = 1'b0;
    chk("reply_data", {24'h0, rdat}, 32'hC3);
    chk("latch_rd_pulse", {31'h0, latch_rd}, 1);
    latch_rdy = 1'b0;
    idle(2);
    chk("irq_after_read", {31'h0, bus.irq}, {31'h0, m_pend & m_en});
    chk("latch_rd_count", rd_pulses, 1);

    // masked IRQ, then unmask and ack
    bus_write(SEL_STAT, 8'h00);
    latch_dout = 8'h3C;
    latch_rdy  = 1'b1;
    m_pend     = 1'b1;
    idle(2);
    chk("irq_masked", {31'h0, bus.irq}, {31'h0, m_pend & m_en});
    check_status("masked_status");
    bus_write(SEL_STAT, 8'h01);
    idle(1);
    chk("irq_unmasked", {31'h0, bus.irq}, {31'h0, m_pend & m_en});
    bus_write(SEL_ACK, 8'h00);
    idle(1);
    chk("irq_acked", {31'h0, bus.irq}, {31'h0, m_pend & m_en});
    latch_rdy = 1'b0;
    idle(2);

    // reset while holding with two bytes queued
    bus_write(SEL_DATA, 8'hD1);
    idle(5);
    bus_write(SEL_DATA, 8'hD2);
    bus_write(SEL_DATA, 8'hD3);
    idle(10);
    do_reset();
    idle(GAP * 3);
    check_status("post_reset_status");
    bus_write(SEL_DATA, 8'hE7);
    drain("post_reset_drain");

    // random command traffic with occasional flushes and status reads
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          n = $urandom_range(2, 6);
          for (int k = 0; k < n; k++) bus_write(SEL_DATA, 8'($urandom));
        end
        1: begin
          bus_write(SEL_DATA, 8'($urandom));
          idle($urandom_range(0, 400));
        end
        2: check_status("rand_status");
        3: idle($urandom_range(1, 300));
        default: begin
          if (!send_at(cyc)) bus_write(SEL_STAT, 8'h03);
          idle($urandom_range(0, 20));
        end
      endcase
    end
    drain("rand_drain");
    idle(GAP + 10);
    check_status("final_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
